wdt_heartbeat_kicker: RTL and testbench
=======================================

# wdt_heartbeat_kicker

Periodic kick generator for the user-domain watchdog. It drives the watchdog's kick input with single-cycle pulses at a programmable interval. Kicks continue only while software proves liveness via `alive_i` strobes. After too many consecutive windows without a strobe, the block stops kicking on purpose, so the watchdog's timeout expires and it issues the system reset.

## Interface
Parameters:
- `CntWidth`, 32: width of the window period and the window counter.
- `MissWidth`, 4: width of the miss counter and of the tolerance input.

Ports:
- `clk_i` in 1: single clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `en_i` in 1: enable; low forces IDLE.
- `period_i` in `CntWidth`: window length P in cycles; 0 is treated as 1.
- `max_miss_i` in `MissWidth`: tolerated consecutive missed windows before starving.
- `alive_i` in 1: software heartbeat strobe (level sampled each cycle).
- `kick_o` out 1: kick pulse to the watchdog kick input; registered.
- `starving_o` out 1: high while in STARVE; registered.
- `miss_cnt_o` out `MissWidth`: current consecutive miss count; saturates at all-ones.

## Operation
- FSM states: IDLE, COUNT, KICK, STARVE.
- Reset (async): state IDLE, `kick_o`=0, `starving_o`=0, `miss_cnt_o`=0, window counter 0, `alive_seen` 0, latched period 0.
- `en_i`=0 in any state: next state IDLE, counter cleared, `alive_seen` cleared, `miss_cnt_o` cleared.
- IDLE:
  - `kick_o`=0, `starving_o`=0.
  - With `en_i`=1, go to COUNT. Latch P = max(`period_i`, 1), clear counter and `alive_seen`.
- COUNT:
  - Counter increments every cycle.
  - `alive_i`=1 sets sticky `alive_seen`.
  - Window end is the cycle in which counter == P-1.
  - At window end, if `alive_seen` or `alive_i` is set: clear miss count, go to KICK.
  - At window end with no alive: miss count = sat(miss+1).
    - If the new value ≤ `max_miss_i`, go to KICK (tolerated miss).
    - Otherwise go to STARVE.
- KICK:
  - `kick_o`=1 for exactly this one cycle.
  - Re-latch P from `period_i`, clear counter and `alive_seen`.
  - `alive_i` seen in this cycle counts toward the next window.
  - Next state COUNT.
- STARVE:
  - `kick_o`=0, `starving_o`=1.
  - Held until `en_i`=0 or reset.
  - `alive_i` is ignored; no self-recovery.
- `max_miss_i` is read live at each window end. `max_miss_i`=0 means the first miss starves.
- Changes to `period_i` mid-window take effect at the next latch point.

## Timing
- `en_i` rises in the cycle before edge 0. COUNT occupies cycles 1..P, the first KICK is in cycle P+1, and KICK cycles repeat every P+1 cycles after that.
- Kick interval is P+1 cycles. Software programs P+1 < watchdog timeout.
- `starving_o` rises one cycle after the failing window end, in the cycle where KICK would have occurred.
- `miss_cnt_o` updates in the same cycle the KICK or STARVE state is entered.
- If `en_i` falls during COUNT, there is no kick. If it falls during KICK, the pulse already issued stands.
- `rst_i` mid-operation: all outputs return to reset values immediately, independent of the clock.
- Arithmetic:
  - Counter compare is unsigned, full `CntWidth`.
  - Counter never exceeds P-1, so no wrap.
  - Miss counter saturates, no wrap.

## Structure
- Package `wdt_pkg`: FSM state enum typedef, `DefaultPeriod` constant, and `CntWidth`/`MissWidth` default localparams. These are shared with the watchdog integration.
- One sub-module: `wdt_window_timer`, containing the latched period, the counter and the `window_end` flag, with clear/load inputs.
- The FSM, the alive latch and the miss counter live in the top module.

## Test plan
- P=4, `alive_i` pulsed once per window: `kick_o` 1-cycle pulses every 5 cycles, `miss_cnt_o`=0, `starving_o`=0.
- P=4, `max_miss_i`=2, no alive: windows 1 and 2 end with a kick and `miss_cnt_o`=1, then 2. Window 3 enters STARVE: `starving_o`=1, no further kicks for 50 cycles.
- Alive edge cases:
  - `alive_i` only on the last COUNT cycle counts as alive (kick, miss 0).
  - `alive_i` only in the KICK cycle credits the following window.
- `period_i`=0: kick every 2 cycles. `period_i` changed 4→8 mid-window: the current window stays 4, the next window is 8.
- STARVE recovery and reset:
  - `en_i` dropped in STARVE: IDLE next cycle, all outputs 0.
  - Re-enable gives a fresh window with `miss_cnt_o`=0.
  - `rst_i` asserted during KICK: `kick_o` falls without a clock edge.
- Integration with watchdog timeout=10:
  - P=8 with heartbeats keeps `sys_rst` low for 200 cycles.
  - Stopping heartbeats with `max_miss_i`=0: `sys_rst` asserts 10 cycles after the last kick.

Source files
------------

// File: rtl/wdt_pkg.sv
// Shared types and defaults for the heartbeat kicker
// and the watchdog integration.
package wdt_pkg;

  localparam int CntWidth  = 32;
  localparam int MissWidth = 4;

  localparam logic [CntWidth-1:0] DefaultPeriod = 32'd1000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COUNT,
    ST_KICK,
    ST_STARVE
  } wdt_state_e;

endpackage

// File: rtl/wdt_window_timer.sv
// Window timer: latched period, cycle counter and
// the window-end flag (counter == P-1).
module wdt_window_timer #(
  parameter int CntWidth = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                i_load,
  input  logic                i_clear,
  input  logic                i_run,
  input  logic [CntWidth-1:0] i_period,
  output logic                o_window_end
);

  localparam logic [CntWidth-1:0] One = {{(CntWidth-1){1'b0}}, 1'b1};

  logic [CntWidth-1:0] r_period;
  logic [CntWidth-1:0] r_cnt;
  logic [CntWidth-1:0] w_period_eff;

  // A zero period behaves like a one-cycle window.
  assign w_period_eff = (i_period == '0) ? One : i_period;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_period <= '0;
      r_cnt    <= '0;
    end else if (i_load) begin
      r_period <= w_period_eff;
      r_cnt    <= '0;
    end else if (i_clear) begin
      r_cnt    <= '0;
    end else if (i_run) begin
      r_cnt    <= r_cnt + One;
    end
  end

  assign o_window_end = (r_cnt == (r_period - One));

endmodule

// File: rtl/wdt_heartbeat_kicker.sv
// Heartbeat-gated watchdog kicker: kicks every P+1 cycles while
// software stays alive, starves the watchdog after too many misses.
module wdt_heartbeat_kicker #(
  parameter int CntWidth  = wdt_pkg::CntWidth,
  parameter int MissWidth = wdt_pkg::MissWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic [CntWidth-1:0]  period_i,
  input  logic [MissWidth-1:0] max_miss_i,
  input  logic                 alive_i,
  output logic                 kick_o,
  output logic                 starving_o,
  output logic [MissWidth-1:0] miss_cnt_o
);

  import wdt_pkg::*;

  wdt_state_e r_state;
  wdt_state_e w_next;

  logic                 r_kick;
  logic                 r_starve;
  logic                 r_alive_seen;
  logic [MissWidth-1:0] r_miss;

  logic                 w_alive_next;
  logic [MissWidth-1:0] w_miss_next;
  logic [MissWidth-1:0] w_miss_inc;
  logic                 w_alive_any;
  logic                 w_load;
  logic                 w_clear;
  logic                 w_run;
  logic                 w_window_end;

  wdt_window_timer #(
    .CntWidth (CntWidth)
  ) u_timer (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .i_load       (w_load),
    .i_clear      (w_clear),
    .i_run        (w_run),
    .i_period     (period_i),
    .o_window_end (w_window_end)
  );

  assign w_miss_inc  = (&r_miss) ? r_miss : r_miss + 1'b1;
  assign w_alive_any = r_alive_seen | alive_i;

  always_comb begin
    w_next       = r_state;
    w_miss_next  = r_miss;
    w_alive_next = r_alive_seen;
    w_load       = 1'b0;
    w_clear      = 1'b0;
    w_run        = 1'b0;
    if (!en_i) begin
      w_next       = ST_IDLE;
      w_clear      = 1'b1;
      w_alive_next = 1'b0;
      w_miss_next  = '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          w_next       = ST_COUNT;
          w_load       = 1'b1;
          w_alive_next = 1'b0;
        end
        ST_COUNT: begin
          w_run        = 1'b1;
          w_alive_next = w_alive_any;
          if (w_window_end) begin
            w_clear      = 1'b1;
            w_alive_next = 1'b0;
            if (w_alive_any) begin
              w_miss_next = '0;
              w_next      = ST_KICK;
            end else begin
              w_miss_next = w_miss_inc;
              w_next      = (w_miss_inc <= max_miss_i) ? ST_KICK
                                                        : ST_STARVE;
            end
          end
        end
        ST_KICK: begin
          // A strobe during the kick cycle credits the next window.
          w_next       = ST_COUNT;
          w_load       = 1'b1;
          w_alive_next = alive_i;
        end
        ST_STARVE: begin
          w_next = ST_STARVE;
        end
        default: begin
          w_next = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= ST_IDLE;
      r_kick       <= 1'b0;
      r_starve     <= 1'b0;
      r_alive_seen <= 1'b0;
      r_miss       <= '0;
    end else begin
      r_state      <= w_next;
      r_kick       <= (w_next == ST_KICK);
      r_starve     <= (w_next == ST_STARVE);
      r_alive_seen <= w_alive_next;
      r_miss       <= w_miss_next;
    end
  end

  assign kick_o     = r_kick;
  assign starving_o = r_starve;
  assign miss_cnt_o = r_miss;

endmodule

// File: tb/tb_wdt_heartbeat_kicker.sv
// Directed bench for the heartbeat kicker with a
// small watchdog model (timeout 10) for integration.
module tb_wdt_heartbeat_kicker;

  logic        clk;
  logic        rst;
  logic        en;
  logic [31:0] period;
  logic [3:0]  max_miss;
  logic        alive;
  logic        kick;
  logic        starving;
  logic [3:0]  miss;

  int checks = 0;
  int errors = 0;

  logic [4:0] wd_cnt;
  logic       sys_rst;

  wdt_heartbeat_kicker #(
    .CntWidth  (32),
    .MissWidth (4)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .en_i       (en),
    .period_i   (period),
    .max_miss_i (max_miss),
    .alive_i    (alive),
    .kick_o     (kick),
    .starving_o (starving),
    .miss_cnt_o (miss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst || !en) wd_cnt <= 5'd0;
    else if (kick) wd_cnt <= 5'd1;
    else if (wd_cnt < 5'd20) wd_cnt <= wd_cnt + 5'd1;
  end
  assign sys_rst = (wd_cnt >= 5'd10);

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int kicks;
    int bad;
    int last_k;
    int first_r;
    rst = 1'b1; en = 1'b0; period = 32'd4;
    max_miss = 4'd2; alive = 1'b0;
    #12;
    chk("rst_kick", {31'd0, kick}, 0);
    chk("rst_starve", {31'd0, starving}, 0);
    chk("rst_miss", {28'd0, miss}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // alive once per window, P=4
    en = 1'b1;
    for (int w = 0; w < 3; w++) begin
      tick(1);
      chk("hb_c1_nokick", {31'd0, kick}, 0);
      alive = 1'b1;
      tick(1);
      alive = 1'b0;
      tick(2);
      chk("hb_c4_nokick", {31'd0, kick}, 0);
      tick(1);
      chk("hb_kick", {31'd0, kick}, 1);
      chk("hb_miss", {28'd0, miss}, 0);
      chk("hb_starve", {31'd0, starving}, 0);
    end
    tick(1);
    chk("hb_kick_1cyc", {31'd0, kick}, 0);

    // restart, no alive, max_miss=2
    en = 1'b0;
    tick(1);
    en = 1'b1;
    tick(5);
    chk("miss1_kick", {31'd0, kick}, 1);
    chk("miss1_cnt", {28'd0, miss}, 1);
    tick(5);
    chk("miss2_kick", {31'd0, kick}, 1);
    chk("miss2_cnt", {28'd0, miss}, 2);
    tick(5);
    chk("starve_kick", {31'd0, kick}, 0);
    chk("starve_flag", {31'd0, starving}, 1);
    chk("starve_miss", {28'd0, miss}, 3);
    kicks = 0; bad = 0;
    for (int i = 0; i < 50; i++) begin
      alive = i[0];
      tick(1);
      if (kick) kicks++;
      if (!starving) bad++;
    end
    alive = 1'b0;
    chk("starve_nokicks", kicks, 0);
    chk("starve_held", bad, 0);

    // drop enable in STARVE
    en = 1'b0;
    tick(1);
    chk("idle_kick", {31'd0, kick}, 0);
    chk("idle_starve", {31'd0, starving}, 0);
    chk("idle_miss", {28'd0, miss}, 0);

    // fresh window, alive edge cases, max_miss=0
    en = 1'b1; max_miss = 4'd0;
    tick(4);
    chk("fresh_miss", {28'd0, miss}, 0);
    chk("fresh_starve", {31'd0, starving}, 0);
    chk("fresh_nokick", {31'd0, kick}, 0);
    alive = 1'b1;
    tick(1);
    chk("last_cyc_kick", {31'd0, kick}, 1);
    chk("last_cyc_miss", {28'd0, miss}, 0);
    tick(1);
    alive = 1'b0;
    tick(4);
    chk("kick_cyc_credit", {31'd0, kick}, 1);
    chk("kick_cyc_miss", {28'd0, miss}, 0);
    tick(5);
    chk("first_miss_starve", {31'd0, starving}, 1);
    chk("first_miss_cnt", {28'd0, miss}, 1);

    // period 0 behaves as 1
    en = 1'b0;
    tick(1);
    en = 1'b1; period = 32'd0; alive = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("p0_count", {31'd0, kick}, 0);
      tick(1);
      chk("p0_kick", {31'd0, kick}, 1);
    end

    // period change mid-window
    en = 1'b0;
    tick(1);
    en = 1'b1; period = 32'd4;
    tick(2);
    period = 32'd8;
    tick(3);
    chk("pchg_old_win", {31'd0, kick}, 1);
    tick(5);
    chk("pchg_no_short", {31'd0, kick}, 0);
    tick(4);
    chk("pchg_new_win", {31'd0, kick}, 1);

    // async reset during KICK
    rst = 1'b1;
    #1;
    chk("async_rst_kick", {31'd0, kick}, 0);
    chk("async_rst_miss", {28'd0, miss}, 0);
    rst = 1'b0;
    en = 1'b0;
    tick(2);

    // integration: timeout 10, P=8
    en = 1'b1; period = 32'd8; max_miss = 4'd0; alive = 1'b1;
    kicks = 0; bad = 0;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (kick) kicks++;
      if (sys_rst) bad++;
    end
    chk("int_kicks", kicks, 22);
    chk("int_no_sysrst", bad, 0);
    alive = 1'b0;
    last_k = -1; first_r = -1;
    for (int i = 1; i <= 60; i++) begin
      tick(1);
      if (kick) last_k = i;
      if (sys_rst && first_r < 0) first_r = i;
    end
    chk("int_starving", {31'd0, starving}, 1);
    chk("int_sysrst_seen", {31'd0, first_r >= 0}, 1);
    chk("int_sysrst_delay", first_r - last_k, 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
